// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline hazard controller:
//   - state_t   : controller FSM encodings (RUN=0, DWAIT=1, HALT=2)
//   - REG_ZERO  : architectural zero register number (never a real dependency)
//   - ctrl_t    : bundle of per-stage enable/flush controls
//   - ctrl_uniform / ctrl_hazard : helpers producing control bundles
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic pc_enable;
    logic ifid_enable;
    logic ifid_flush;
    logic idex_enable;
    logic idex_flush;
    logic exmem_enable;
    logic memwb_enable;
  } ctrl_t;

  // Every enable set to 'en', no flushes.
  function automatic ctrl_t ctrl_uniform(input logic en);
    ctrl_t c;
    c.pc_enable    = en;
    c.ifid_enable  = en;
    c.ifid_flush   = 1'b0;
    c.idex_enable  = en;
    c.idex_flush   = 1'b0;
    c.exmem_enable = en;
    c.memwb_enable = en;
    return c;
  endfunction

  // Priority-ordered hazard resolution once data memory is not blocking:
  // taken branch, then load-use, then fetch wait, else free running.
  function automatic ctrl_t ctrl_hazard(input logic branch_taken,
                                        input logic load_use,
                                        input logic imem_ready);
    ctrl_t c;
    c = ctrl_uniform(1'b1);
    if (branch_taken) begin
      // PC takes the branch target; the two wrong-path instructions die.
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject one bubble into EX.
      c.pc_enable   = 1'b0;
      c.ifid_enable = 1'b0;
      c.idex_flush  = 1'b1;
    end else if (!imem_ready) begin
      // No valid fetch: hold PC, feed a bubble into ID, let the rest drain.
      c.pc_enable  = 1'b0;
      c.ifid_flush = 1'b1;
    end else begin
      c = ctrl_uniform(1'b1);
    end
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector: flags when the instruction in
// ID reads a register that the load currently in EX is about to write.
// Ports:
//   ex_mem_read  in  EX instruction is a load
//   ex_rt        in  load destination register
//   id_rs/id_rt  in  source registers of the ID instruction
//   id_uses_rs/rt in ID instruction actually reads rs / rt
//   load_use     out hazard present
// -----------------------------------------------------------------------------
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  output logic             load_use
);

  logic rs_hit;
  logic rt_hit;

  // A load into $zero never creates a dependency.
  always_comb begin
    rs_hit   = id_uses_rs & (id_rs == ex_rt);
    rt_hit   = id_uses_rt & (id_rt == ex_rt);
    load_use = ex_mem_read & (ex_rt != REG_W'(REG_ZERO)) & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Sequences the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers of a
// 5-stage MIPS pipeline. Handles load-use stalls, taken-branch flushes, fetch
// wait bubbles and data-memory wait freezes. A watchdog halts the pipeline when
// a data access stays not-ready for MAX_DWAIT consecutive cycles; only reset
// leaves HALT. Saturating counters record PC-hold cycles and branch flushes.
// Ports:
//   clk, reset (sync, active-high)
//   id_rs, id_rt, id_uses_rs, id_uses_rt   ID-stage operand info
//   ex_mem_read, ex_rt, ex_branch_taken    EX-stage info
//   imem_ready, dmem_req, dmem_ready       memory handshakes
//   pc_enable, *_enable, *_flush           combinational stage controls
//   halted, state_dbg                      watchdog trip / FSM state
//   stall_count, flush_count               saturating perf counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int CNT_W     = 32,
  parameter int MAX_DWAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             ifid_flush,
  output logic             idex_enable,
  output logic             idex_flush,
  output logic             exmem_enable,
  output logic             memwb_enable,
  output logic             halted,
  output logic [1:0]       state_dbg,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // wait_cnt only has to reach MAX_DWAIT-1.
  localparam int              WC_W    = (MAX_DWAIT > 2) ? $clog2(MAX_DWAIT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_DWAIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  ctrl_t           ctrl;
  logic            load_use;
  logic            dmem_block;
  logic            branch_flush;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  // Stage controls from current state and inputs; a freeze blocks everything.
  always_comb begin
    ctrl         = ctrl_uniform(1'b1);
    dmem_block   = 1'b0;
    branch_flush = 1'b0;
    if (reset) begin
      ctrl = ctrl_uniform(1'b1);
    end else begin
      case (state)
        ST_RUN: begin
          if (dmem_req && !dmem_ready) begin
            ctrl       = ctrl_uniform(1'b0);
            dmem_block = 1'b1;
          end else begin
            ctrl         = ctrl_hazard(ex_branch_taken, load_use, imem_ready);
            branch_flush = ex_branch_taken;
          end
        end
        ST_DWAIT: begin
          // The completing cycle is a normal cycle, so no slot is lost.
          if (!dmem_ready) begin
            ctrl       = ctrl_uniform(1'b0);
            dmem_block = 1'b1;
          end else begin
            ctrl         = ctrl_hazard(ex_branch_taken, load_use, imem_ready);
            branch_flush = ex_branch_taken;
          end
        end
        ST_HALT: begin
          ctrl = ctrl_uniform(1'b0);
        end
        default: begin
          ctrl = ctrl_uniform(1'b0);
        end
      endcase
    end
  end

  // Drive the individual control ports from the bundle.
  always_comb begin
    pc_enable    = ctrl.pc_enable;
    ifid_enable  = ctrl.ifid_enable;
    ifid_flush   = ctrl.ifid_flush;
    idex_enable  = ctrl.idex_enable;
    idex_flush   = ctrl.idex_flush;
    exmem_enable = ctrl.exmem_enable;
    memwb_enable = ctrl.memwb_enable;
    state_dbg    = state;
  end

  // FSM, dmem watchdog and saturating perf counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      wait_cnt    <= {WC_W{1'b0}};
      halted      <= 1'b0;
      stall_count <= {CNT_W{1'b0}};
      flush_count <= {CNT_W{1'b0}};
    end else begin
      if (!ctrl.pc_enable && (state != ST_HALT) && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (branch_flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
      case (state)
        ST_RUN: begin
          if (dmem_block) begin
            state    <= ST_DWAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        ST_DWAIT: begin
          if (dmem_block) begin
            if (wait_cnt == WC_LAST) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WC_W'(1);
            end
          end else begin
            state    <= ST_RUN;
            wait_cnt <= {WC_W{1'b0}};
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park safely until reset.
          state  <= ST_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int MAXD = 4;
  localparam int CW   = 4;
  localparam int SAT  = 15;

  localparam logic [6:0] C_RUN = 7'b1101011;
  localparam logic [6:0] C_OFF = 7'b0000000;
  localparam logic [6:0] C_BR  = 7'b1111111;
  localparam logic [6:0] C_LU  = 7'b0001111;
  localparam logic [6:0] C_IM  = 7'b0111011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
  logic          imem_ready, dmem_req, dmem_ready;
  logic          pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic          exmem_enable, memwb_enable, halted;
  logic [1:0]    state_dbg;
  logic [CW-1:0] stall_count, flush_count;
  logic [6:0]    ctl_now;

  assign ctl_now = {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
                    exmem_enable, memwb_enable};

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(CW), .MAX_DWAIT(MAXD)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
    .halted(halted), .state_dbg(state_dbg),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic       imem;
    logic       dreq;
    logic       drdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [6:0] ctl;
    int         dstall;
    int         dflush;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Reference model: mode (0 run, 1 waiting on dmem, 2 halted), consecutive
  // not-ready cycles of the current access, and the two event tallies.
  int m_state = 0;
  int m_dcnt  = 0;
  int m_stall = 0;
  int m_flush = 0;
  int m_halted = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic in_t mkv(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic mr,
                              input logic [4:0] ert, input logic br, input logic imem,
                              input logic dreq, input logic drdy);
    in_t v;
    v.rst = 1'b0; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr;
    v.ert = ert; v.br = br; v.imem = imem; v.dreq = dreq; v.drdy = drdy;
    return v;
  endfunction

  function automatic logic [6:0] model_ctl(input in_t v, output bit br_hit);
    bit blocked;
    bit lu;
    br_hit = 1'b0;
    if (v.rst) return C_RUN;
    if (m_state == 2) return C_OFF;
    if (m_state == 1) blocked = !v.drdy;
    else blocked = v.dreq && !v.drdy;
    if (blocked) return C_OFF;
    lu = v.mr && (v.ert != 5'd0) &&
         ((v.urs && (v.rs == v.ert)) || (v.urt && (v.rt == v.ert)));
    if (v.br) begin
      br_hit = 1'b1;
      return C_BR;
    end
    if (lu) return C_LU;
    if (!v.imem) return C_IM;
    return C_RUN;
  endfunction

  task automatic model_step(input in_t v, input logic [6:0] ctl, input bit br_hit);
    if (v.rst) begin
      m_state = 0; m_dcnt = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_state != 2 && ctl[6] == 1'b0 && m_stall < SAT) m_stall++;
      if (br_hit && m_flush < SAT) m_flush++;
      if (m_state == 0) begin
        if (v.dreq && !v.drdy) begin
          m_state = 1;
          m_dcnt  = 1;
        end
      end else if (m_state == 1) begin
        if (v.drdy) begin
          m_state = 0;
          m_dcnt  = 0;
        end else begin
          m_dcnt++;
          if (m_dcnt >= MAXD) begin
            m_state  = 2;
            m_halted = 1;
          end
        end
      end
    end
  endtask

  task automatic run_cycle(input in_t v, output logic [6:0] seen);
    logic [6:0] e;
    bit b;
    reset = v.rst; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_mem_read = v.mr; ex_rt = v.ert; ex_branch_taken = v.br;
    imem_ready = v.imem; dmem_req = v.dreq; dmem_ready = v.drdy;
    #2;
    e = model_ctl(v, b);
    seen = ctl_now;
    chk("ctl", 32'(ctl_now), 32'(e));
    @(posedge clk);
    #1;
    model_step(v, e, b);
    chk("state_dbg", 32'(state_dbg), 32'(m_state));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    chk("flush_count", 32'(flush_count), 32'(m_flush));
  endtask

  initial begin
    vec_t       tbl[10];
    in_t        v;
    in_t        rv;
    in_t        idle;
    logic [6:0] s;
    int         es;
    int         ef;

    idle = mkv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    rv = idle;
    rv.rst = 1'b1;

    tbl[0] = '{"lu_rs",        mkv(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0), C_LU,  1, 0};
    tbl[1] = '{"lu_zero_reg",  mkv(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), C_RUN, 0, 0};
    tbl[2] = '{"br_over_lu",   mkv(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0), C_BR,  0, 1};
    tbl[3] = '{"imem_wait",    mkv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), C_IM,  1, 0};
    tbl[4] = '{"lu_rt",        mkv(5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0), C_LU,  1, 0};
    tbl[5] = '{"no_use",       mkv(5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0), C_RUN, 0, 0};
    tbl[6] = '{"br_over_imem", mkv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), C_BR,  0, 1};
    tbl[7] = '{"lu_over_imem", mkv(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0), C_LU,  1, 0};
    tbl[8] = '{"no_load",      mkv(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0), C_RUN, 0, 0};
    tbl[9] = '{"dmem_hit",     mkv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1), C_RUN, 0, 0};

    // Reset and reset-state checks
    run_cycle(rv, s);
    chk("reset_ctl", 32'(s), 32'(C_RUN));
    run_cycle(rv, s);
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_stall", 32'(stall_count), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);

    // Single-cycle rule table from RUN
    es = 0;
    ef = 0;
    for (int i = 0; i < 10; i++) begin
      run_cycle(tbl[i].in, s);
      chk(tbl[i].name, 32'(s), 32'(tbl[i].ctl));
      es += tbl[i].dstall;
      ef += tbl[i].dflush;
      chk({tbl[i].name, "_stall"}, 32'(stall_count), 32'(es));
      chk({tbl[i].name, "_flush"}, 32'(flush_count), 32'(ef));
      chk({tbl[i].name, "_state"}, 32'(state_dbg), 32'd0);
    end

    // Data-memory wait released after three not-ready cycles
    run_cycle(rv, s);
    v = idle;
    v.dreq = 1'b1;
    v.drdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run_cycle(v, s);
      chk("dwait_ctl", 32'(s), 32'(C_OFF));
      chk("dwait_state", 32'(state_dbg), 32'd1);
    end
    v.drdy = 1'b1;
    run_cycle(v, s);
    chk("dwait_release_ctl", 32'(s), 32'(C_RUN));
    chk("dwait_release_state", 32'(state_dbg), 32'd0);
    chk("dwait_stalls", 32'(stall_count), 32'd3);

    // Watchdog trip after MAXD not-ready cycles, stays halted, reset recovers
    run_cycle(rv, s);
    v.drdy = 1'b0;
    for (int k = 0; k < MAXD; k++) run_cycle(v, s);
    chk("wd_halted", 32'(halted), 32'd1);
    chk("wd_state", 32'(state_dbg), 32'd2);
    chk("wd_stalls", 32'(stall_count), 32'(MAXD));
    v = idle;
    v.drdy = 1'b1;
    v.br = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_cycle(v, s);
      chk("halt_ctl", 32'(s), 32'(C_OFF));
      chk("halt_state", 32'(state_dbg), 32'd2);
    end
    chk("halt_no_flush", 32'(flush_count), 32'd0);
    chk("halt_no_stall", 32'(stall_count), 32'(MAXD));
    run_cycle(rv, s);
    chk("halt_reset_ctl", 32'(s), 32'(C_RUN));
    chk("halt_reset_state", 32'(state_dbg), 32'd0);
    chk("halt_reset_halted", 32'(halted), 32'd0);
    chk("halt_reset_stall", 32'(stall_count), 32'd0);

    // Counter saturation
    v = idle;
    v.imem = 1'b0;
    for (int k = 0; k < 20; k++) run_cycle(v, s);
    chk("stall_saturate", 32'(stall_count), 32'(SAT));
    v = idle;
    v.br = 1'b1;
    for (int k = 0; k < 20; k++) run_cycle(v, s);
    chk("flush_saturate", 32'(flush_count), 32'(SAT));

    // Randomized traffic against the model
    run_cycle(rv, s);
    for (int n = 0; n < 3000; n++) begin
      v.rst  = ($urandom_range(0, 39) == 0);
      v.rs   = 5'($urandom_range(0, 3));
      v.rt   = 5'($urandom_range(0, 3));
      v.urs  = 1'($urandom_range(0, 1));
      v.urt  = 1'($urandom_range(0, 1));
      v.mr   = 1'($urandom_range(0, 1));
      v.ert  = 5'($urandom_range(0, 3));
      v.br   = ($urandom_range(0, 5) == 0);
      v.imem = ($urandom_range(0, 4) != 0);
      v.dreq = ($urandom_range(0, 2) == 0);
      v.drdy = 1'($urandom_range(0, 1));
      run_cycle(v, s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
